// File: rtl/seq_divmod_if.sv
// Operand/result handshake bundle for seq_divmod.
// master drives operands and result acceptance; slave is the divider.
interface seq_divmod_if #(
  parameter int DATAWIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] quot;
  logic [DATAWIDTH-1:0] rem;
  logic                 dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quot, rem, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quot, rem, dz
  );
endinterface

// File: rtl/seq_divmod.sv
// Iterative restoring divider, one quotient bit per cycle.
// Signed mode divides magnitudes and fixes signs on the last step.
module seq_divmod #(
  parameter int DATAWIDTH = 8,
  parameter bit SIGNED    = 1'b0
) (
  input logic        Clk,
  input logic        Rst_n,
  seq_divmod_if.slave io
);
  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic [W-1:0]  qr;
  logic [W-1:0]  dv;
  logic [W:0]    pr;
  logic          nq;
  logic          nr;

  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  amag;
  logic [W-1:0]  bmag;
  logic [W:0]    sh;
  logic [W:0]    df;
  logic          take;
  logic [W:0]    npr;
  logic [W-1:0]  nqr;
  logic [W-1:0]  fq;
  logic [W-1:0]  fr;

  always_comb begin
    a_neg = SIGNED && io.a[W-1];
    b_neg = SIGNED && io.b[W-1];
    amag  = a_neg ? -io.a : io.a;
    bmag  = b_neg ? -io.b : io.b;
    // pr[W] is always clear after a restore
    sh    = {pr[W-1:0], qr[W-1]};
    df    = sh - {1'b0, dv};
    take  = !df[W];
    npr   = take ? df : sh;
    nqr   = {qr[W-2:0], take};
    fq    = nq ? -nqr : nqr;
    fr    = nr ? -npr[W-1:0] : npr[W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      st           <= IDLE;
      cnt          <= '0;
      qr           <= '0;
      dv           <= '0;
      pr           <= '0;
      nq           <= 1'b0;
      nr           <= 1'b0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.quot      <= '0;
      io.rem       <= '0;
      io.dz        <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (io.in_valid) begin
            io.in_ready <= 1'b0;
            if (io.b == '0) begin
              st           <= DONE;
              io.out_valid <= 1'b1;
              io.quot      <= '1;
              io.rem       <= io.a;
              io.dz        <= 1'b1;
            end else begin
              st  <= CALC;
              cnt <= CW'(W - 1);
              qr  <= amag;
              dv  <= bmag;
              pr  <= '0;
              nq  <= a_neg ^ b_neg;
              nr  <= a_neg;
            end
          end
        end
        CALC: begin
          pr  <= npr;
          qr  <= nqr;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            st           <= DONE;
            io.out_valid <= 1'b1;
            io.quot      <= fq;
            io.rem       <= fr;
            io.dz        <= 1'b0;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            st           <= IDLE;
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divmod.sv
// Bench for seq_divmod: eight widths/signedness variants fed the same
// operands, checked against plain / and % arithmetic.
module tb_seq_divmod;
  logic        Clk;
  logic        Rst_n;
  logic        iv;
  logic        ordy;
  logic [63:0] A;
  logic [63:0] B;

  logic [63:0] oq  [8];
  logic [63:0] orr [8];
  logic [7:0]  odz;
  logic [7:0]  ov;
  logic [7:0]  ir;

  int tests = 0;
  int fails = 0;
  int lat8;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  for (genvar k = 0; k < 8; k++) begin : g
    localparam int W = (k < 2) ? 2 : (k < 4) ? 8 : (k < 6) ? 32 : 64;
    seq_divmod_if #(.DATAWIDTH(W)) bus ();
    seq_divmod #(
      .DATAWIDTH(W),
      .SIGNED   (k % 2)
    ) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .io   (bus)
    );
    assign bus.in_valid  = iv;
    assign bus.out_ready = ordy;
    assign bus.a         = A[W-1:0];
    assign bus.b         = B[W-1:0];
    assign oq[k]         = 64'(bus.quot);
    assign orr[k]        = 64'(bus.rem);
    assign odz[k]        = bus.dz;
    assign ov[k]         = bus.out_valid;
    assign ir[k]         = bus.in_ready;
  end

  function automatic int wof(int k);
    return (k < 2) ? 2 : (k < 4) ? 8 : (k < 6) ? 32 : 64;
  endfunction

  // Reference: truncate to width, then ordinary integer division
  function automatic void model(
    input  int          w,
    input  bit          sg,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] q,
    output logic [63:0] r,
    output logic        z
  );
    logic [63:0] m;
    logic [63:0] ua;
    logic [63:0] ub;
    longint      sa;
    longint      sb;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua = a & m;
    ub = b & m;
    if (ub == 0) begin
      q = m;
      r = ua;
      z = 1'b1;
      return;
    end
    z = 1'b0;
    if (!sg) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      sa = longint'(ua << (64 - w)) >>> (64 - w);
      sb = longint'(ub << (64 - w)) >>> (64 - w);
      if (sb == -1) begin
        q = 64'(-sa);
        r = 64'd0;
      end else begin
        q = 64'(sa / sb);
        r = 64'(sa % sb);
      end
    end
    q = q & m;
    r = r & m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  // Present operands; return once every variant shows out_valid.
  // lat8 counts edges from the accept edge inclusive.
  task automatic start(input logic [63:0] a, input logic [63:0] b);
    int  n;
    bit  done;
    @(negedge Clk);
    A    = a;
    B    = b;
    iv   = 1'b1;
    n    = 1;
    lat8 = 0;
    done = 1'b0;
    @(posedge Clk);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge Clk);
      if (c == 0) iv = 1'b0;
      if (ov[2] && lat8 == 0) lat8 = n;
      if (&ov) done = 1'b1;
      else begin
        @(posedge Clk);
        n++;
      end
    end
    if (!done) chk("timeout", 64'(ov), 64'hff);
  endtask

  task automatic checkall();
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
    for (int k = 0; k < 8; k++) begin
      model(wof(k), k[0], A, B, q, r, z);
      chk($sformatf("quot%0d a=%0h b=%0h", k, A, B), oq[k], q);
      chk($sformatf("rem%0d a=%0h b=%0h", k, A, B), orr[k], r);
      chk($sformatf("dz%0d", k), 64'(odz[k]), 64'(z));
    end
  endtask

  task automatic handoff();
    @(negedge Clk);
    ordy = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ordy = 1'b0;
    chk("ready_after", 64'(ir), 64'hff);
    chk("valid_after", 64'(ov), 64'h0);
  endtask

  task automatic op(input logic [63:0] a, input logic [63:0] b);
    start(a, b);
    checkall();
    handoff();
  endtask

  initial begin
    bit          seen;
    logic [63:0] ra;
    logic [63:0] rb;
    int          mode;
    Rst_n = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("rst_ready", 64'(ir), 64'hff);
    chk("rst_valid", 64'(ov), 64'h0);
    chk("rst_quot", oq[2], 64'h0);
    chk("rst_rem", orr[2], 64'h0);
    chk("rst_dz", 64'(odz), 64'h0);

    start(64'd200, 64'd7);
    chk("u8_quot", oq[2], 64'd28);
    chk("u8_rem", orr[2], 64'd4);
    chk("u8_dz", 64'(odz[2]), 64'd0);
    chk("u8_lat", 64'(lat8), 64'd9);
    checkall();
    handoff();

    start(-64'sd7, 64'd2);
    chk("s8_q1", oq[3], 64'hfd);
    chk("s8_r1", orr[3], 64'hff);
    checkall();
    handoff();
    start(64'd7, -64'sd2);
    chk("s8_q2", oq[3], 64'hfd);
    chk("s8_r2", orr[3], 64'h01);
    checkall();
    handoff();
    start(64'h80, 64'hff);
    chk("s8_ovf_q", oq[3], 64'h80);
    chk("s8_ovf_r", orr[3], 64'h00);
    chk("s8_ovf_dz", 64'(odz[3]), 64'd0);
    checkall();
    handoff();

    start(64'h5a, 64'h0);
    chk("dz_lat", 64'(lat8), 64'd1);
    chk("dz_flag", 64'(odz[2]), 64'd1);
    chk("dz_quot", oq[2], 64'hff);
    chk("dz_rem", orr[2], 64'h5a);
    checkall();
    handoff();
    start(64'h11, 64'd3);
    chk("dz_clear", 64'(odz[2]), 64'd0);
    checkall();
    handoff();

    start(64'd250, 64'd9);
    A = 64'd1;
    B = 64'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_quot", oq[2], 64'd27);
      chk("bp_rem", orr[2], 64'd7);
      chk("bp_valid", 64'(ov[2]), 64'd1);
      chk("bp_ready", 64'(ir), 64'h0);
    end
    handoff();

    @(negedge Clk);
    A  = 64'd100;
    B  = 64'd3;
    iv = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    iv = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("midrst_ready", 64'(ir), 64'hff);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (ov != 0) seen = 1'b1;
    end
    chk("midrst_novalid", 64'(seen), 64'd0);
    start(64'd9, 64'd4);
    chk("post_quot", oq[2], 64'd2);
    chk("post_rem", orr[2], 64'd1);
    checkall();
    handoff();

    for (int i = 0; i < 700; i++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 64'd0;
        1: rb = '1;
        2: begin
          ra = 64'h8000_0000_0000_0000;
          rb = '1;
        end
        3: rb = 64'($urandom_range(1, 5));
        4: rb = -64'($urandom_range(1, 5));
        default: ;
      endcase
      op(ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
